// File: rtl/perf_tgen_pkg.sv
// Shared types and constants for the perf_tgen traffic generator:
// FSM states, register offsets and CTRL/STATUS bit positions.
package perf_tgen_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [31:0] OffCtrl     = 32'h00;
  localparam logic [31:0] OffAddr     = 32'h04;
  localparam logic [31:0] OffCount    = 32'h08;
  localparam logic [31:0] OffPattern  = 32'h0C;
  localparam logic [31:0] OffStatus   = 32'h10;
  localparam logic [31:0] OffCycles   = 32'h14;
  localparam logic [31:0] OffChecksum = 32'h18;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlDir   = 1;
  localparam int unsigned CtrlIncr  = 2;
  localparam int unsigned CtrlAbort = 3;

  localparam int unsigned StatBusy = 0;
  localparam int unsigned StatDone = 1;
  localparam int unsigned StatErr  = 2;

endpackage

// File: rtl/perf_tgen_if.sv
// Classic 32-bit Wishbone bundle. dat_o is master-to-slave write data,
// dat_i is slave-to-master read data, named from the master's side.
interface wishbone;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (output cyc, stb, we, sel, adr, dat_o, input dat_i, ack, err, rty);
  modport slave  (input cyc, stb, we, sel, adr, dat_o, output dat_i, ack, err, rty);
endinterface

// File: rtl/perf_tgen_regs.sv
// Configuration/status slave: address decode, register file and readback mux.
// Zero-wait-state; configuration writes are locked out while a burst is running.
module perf_tgen_regs
  import perf_tgen_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h9A000000
) (
  input  logic        clk,
  input  logic        rst,
  wishbone.slave      wb,
  input  logic        busy,
  input  logic        done,
  input  logic        error,
  input  logic [31:0] cycles,
  input  logic [31:0] checksum,
  output logic        start,
  output logic        abort,
  output logic        dir,
  output logic        incr,
  output logic [31:0] addr,
  output logic [15:0] count,
  output logic [31:0] pattern
);

  logic [31:0] off;
  logic        wr;
  logic        wr_ctrl;
  logic        dir_q, incr_q;
  logic [31:0] addr_q, pattern_q, rdata;
  logic [15:0] count_q;
  logic        unused_sel;

  assign off     = wb.adr - BASE_ADR;
  assign wr      = wb.cyc && wb.stb && wb.we;
  assign wr_ctrl = wr && (off == OffCtrl);

  assign wb.ack = wb.cyc && wb.stb;
  assign wb.err = 1'b0;
  assign wb.rty = 1'b0;
  assign unused_sel = ^wb.sel;

  assign start = wr_ctrl && wb.dat_o[CtrlStart] && !busy;
  assign abort = wr_ctrl && wb.dat_o[CtrlAbort];
  // Bypass so the FSM latches the mode carried by the start write itself.
  assign dir   = (wr_ctrl && !busy) ? wb.dat_o[CtrlDir]  : dir_q;
  assign incr  = (wr_ctrl && !busy) ? wb.dat_o[CtrlIncr] : incr_q;

  assign addr    = addr_q;
  assign count   = count_q;
  assign pattern = pattern_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q     <= 1'b0;
      incr_q    <= 1'b0;
      addr_q    <= '0;
      count_q   <= '0;
      pattern_q <= '0;
    end else if (wr && !busy) begin
      case (off)
        OffCtrl: begin
          dir_q  <= wb.dat_o[CtrlDir];
          incr_q <= wb.dat_o[CtrlIncr];
        end
        OffAddr:    addr_q    <= wb.dat_o;
        OffCount:   count_q   <= wb.dat_o[15:0];
        OffPattern: pattern_q <= wb.dat_o;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OffCtrl: begin
        rdata[CtrlDir]  = dir_q;
        rdata[CtrlIncr] = incr_q;
      end
      OffAddr:    rdata = addr_q;
      OffCount:   rdata = {16'h0, count_q};
      OffPattern: rdata = pattern_q;
      OffStatus: begin
        rdata[StatBusy] = busy;
        rdata[StatDone] = done;
        rdata[StatErr]  = error;
      end
      OffCycles:   rdata = cycles;
      OffChecksum: rdata = checksum;
      default: ;
    endcase
  end

  assign wb.dat_i = rdata;

endmodule

// File: rtl/perf_tgen.sv
// Wishbone traffic generator: issues COUNT back-to-back single transfers on wbm,
// accumulating read checksum and cycle count; configured through wb.
module perf_tgen
  import perf_tgen_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h9A000000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic   clk,
  input  logic   rst,
  wishbone.slave wb,
  wishbone.master wbm
);

  state_e      state_q;
  logic        cyc_q, we_q, incr_q, done_q, err_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, dat_q, cycles_q, csum_q, tcnt_q;
  logic [15:0] idx_q, idx_n;
  logic        start, abort, dir, incr, busy, resp, unused_rty;
  logic [31:0] addr, pattern;
  logic [15:0] count;

  perf_tgen_regs #(.BASE_ADR(BASE_ADR)) u_regs (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb),
    .busy     (busy),
    .done     (done_q),
    .error    (err_q),
    .cycles   (cycles_q),
    .checksum (csum_q),
    .start    (start),
    .abort    (abort),
    .dir      (dir),
    .incr     (incr),
    .addr     (addr),
    .count    (count),
    .pattern  (pattern)
  );

  assign busy  = (state_q == StReq);
  assign idx_n = idx_q + 16'd1;
  assign resp  = wbm.ack || wbm.err;
  assign unused_rty = wbm.rty;

  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = cyc_q;
  assign wbm.we    = we_q;
  assign wbm.sel   = sel_q;
  assign wbm.adr   = adr_q;
  assign wbm.dat_o = dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      idx_q    <= '0;
      tcnt_q   <= '0;
      incr_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
      csum_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= StReq;
              cyc_q    <= 1'b1;
              we_q     <= dir;
              sel_q    <= 4'hF;
              adr_q    <= addr;
              dat_q    <= pattern;
              incr_q   <= incr;
              idx_q    <= '0;
              tcnt_q   <= '0;
              done_q   <= 1'b0;
              err_q    <= 1'b0;
              cycles_q <= '0;
              csum_q   <= '0;
            end
          end
        end
        StReq: begin
          if (cycles_q != '1) cycles_q <= cycles_q + 32'd1;
          if (resp) begin
            // err completes the transfer like ack but flags the error.
            idx_q  <= idx_n;
            tcnt_q <= '0;
            if (!we_q)   csum_q <= csum_q + wbm.dat_i;
            if (wbm.err) err_q  <= 1'b1;
            if (abort || idx_n == count) begin
              state_q <= StDone;
              cyc_q   <= 1'b0;
            end else begin
              adr_q <= incr_q ? addr + {14'h0, idx_n, 2'b00} : addr;
              dat_q <= pattern + {16'h0, idx_n};
            end
          end else if (abort) begin
            state_q <= StDone;
            cyc_q   <= 1'b0;
          end else if (tcnt_q == TIMEOUT - 1) begin
            err_q   <= 1'b1;
            state_q <= StDone;
            cyc_q   <= 1'b0;
          end else begin
            tcnt_q <= tcnt_q + 32'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          cyc_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
